// File: rtl/decode_pkg.sv
// Shared widths, instruction field offsets and the sign-extension helper
// for the pipelined decode stage.
package decode_pkg;

  localparam int OPC_W_DEF  = 3;
  localparam int RA_W_DEF   = 3;
  localparam int IMM_W_DEF  = 4;
  localparam int DATA_W_DEF = 16;

  // Instruction layout, MSB first: opcode | rs | rt | rd | imm
  localparam int IMM_LSB_DEF = 0;
  localparam int RD_LSB_DEF  = IMM_W_DEF;
  localparam int RT_LSB_DEF  = IMM_W_DEF + RA_W_DEF;
  localparam int RS_LSB_DEF  = IMM_W_DEF + 2 * RA_W_DEF;
  localparam int OPC_LSB_DEF = IMM_W_DEF + 3 * RA_W_DEF;
  localparam int INSTR_W_DEF = OPC_W_DEF + 3 * RA_W_DEF + IMM_W_DEF;

  localparam logic [2:0] LOAD_OPC_DEF = 3'b100;

  // Sign-extend the low 'width' bits of value to 32 bits; callers truncate
  // to their datapath width.
  function automatic logic [31:0] sign_extend(input logic [31:0] value, input int width);
    logic [31:0] shifted;
    shifted = value << (32 - width);
    return $signed(shifted) >>> (32 - width);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Two-read / one-write register file. R0 is hardwired to zero and a write
// in the same cycle as a read is forwarded to the read port.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int RA_W   = RA_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [RA_W-1:0]   rs,
  input  logic [RA_W-1:0]   rt,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NREG = 2 ** RA_W;

  logic [DATA_W-1:0] mem [NREG];

  // Register array; writes to R0 are dropped so it always reads back zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      mem[wb_addr] <= wb_data;
    end
  end

  // Read ports with write-through from the writeback port.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rs != '0) rdata1 = (wb_en && (wb_addr == rs)) ? wb_data : mem[rs];
    if (rt != '0) rdata2 = (wb_en && (wb_addr == rt)) ? wb_data : mem[rt];
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: field slicing, register read with writeback
// bypass, immediate sign extension, ID/EX register with valid/ready
// handshake, load-use stall and branch flush.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int OPC_W  = OPC_W_DEF,
  parameter int RA_W   = RA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [OPC_W-1:0] LOAD_OPC = OPC_W'(LOAD_OPC_DEF)
) (
  input  logic                              inp_clk,
  input  logic                              inp_rst,
  input  logic [OPC_W+3*RA_W+IMM_W-1:0]     inp_instruction,
  input  logic                              inp_valid,
  output logic                              out_ready,
  input  logic                              inp_flush,
  input  logic                              inp_wb_en,
  input  logic [RA_W-1:0]                   inp_wb_addr,
  input  logic [DATA_W-1:0]                 inp_wb_data,
  output logic                              out_valid,
  input  logic                              inp_ex_ready,
  output logic [OPC_W-1:0]                  out_opcode,
  output logic [RA_W-1:0]                   out_rd,
  output logic [RA_W-1:0]                   out_rt,
  output logic [RA_W-1:0]                   out_rs,
  output logic [DATA_W-1:0]                 out_readdata1,
  output logic [DATA_W-1:0]                 out_readdata2,
  output logic [DATA_W-1:0]                 out_SEImmidate
);

  localparam int RD_LSB  = IMM_W;
  localparam int RT_LSB  = IMM_W + RA_W;
  localparam int RS_LSB  = IMM_W + 2 * RA_W;
  localparam int OPC_LSB = IMM_W + 3 * RA_W;

  logic [OPC_W-1:0]  opc;
  logic [RA_W-1:0]   rs;
  logic [RA_W-1:0]   rt;
  logic [RA_W-1:0]   rd;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              hazard;
  logic              transfer;

  assign opc = inp_instruction[OPC_LSB +: OPC_W];
  assign rs  = inp_instruction[RS_LSB +: RA_W];
  assign rt  = inp_instruction[RT_LSB +: RA_W];
  assign rd  = inp_instruction[RD_LSB +: RA_W];
  assign imm = inp_instruction[0 +: IMM_W];

  decode_regfile #(
    .RA_W   (RA_W),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (inp_clk),
    .rst     (inp_rst),
    .wb_en   (inp_wb_en),
    .wb_addr (inp_wb_addr),
    .wb_data (inp_wb_data),
    .rs      (rs),
    .rt      (rt),
    .rdata1  (rdata1),
    .rdata2  (rdata2)
  );

  // Load-use stall: the loaded register is not available until the load
  // leaves execute, so the dependent instruction waits one cycle upstream.
  always_comb begin
    hazard    = out_valid && (out_opcode == LOAD_OPC) && inp_valid &&
                ((out_rt == rs) || (out_rt == rt));
    out_ready = (!out_valid || inp_ex_ready) && !hazard && !inp_flush;
    transfer  = inp_valid && out_ready;
  end

  // ID/EX register: flush > load > drain > hold. Fields keep their last
  // value once drained; only out_valid marks them live.
  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst) begin
      out_valid      <= 1'b0;
      out_opcode     <= '0;
      out_rs         <= '0;
      out_rt         <= '0;
      out_rd         <= '0;
      out_readdata1  <= '0;
      out_readdata2  <= '0;
      out_SEImmidate <= '0;
    end else if (inp_flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid      <= 1'b1;
      out_opcode     <= opc;
      out_rs         <= rs;
      out_rt         <= rt;
      out_rd         <= rd;
      out_readdata1  <= rdata1;
      out_readdata2  <= rdata2;
      out_SEImmidate <= DATA_W'(sign_extend(32'(imm), IMM_W));
    end else if (inp_ex_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed vector bench for decode_stage_pipe.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        valid;
  logic        ready;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_ready;
  logic        o_valid;
  logic [2:0]  o_opc;
  logic [2:0]  o_rd;
  logic [2:0]  o_rt;
  logic [2:0]  o_rs;
  logic [15:0] o_rd1;
  logic [15:0] o_rd2;
  logic [15:0] o_imm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_pipe dut (
    .inp_clk         (clk),
    .inp_rst         (rst),
    .inp_instruction (instr),
    .inp_valid       (valid),
    .out_ready       (ready),
    .inp_flush       (flush),
    .inp_wb_en       (wb_en),
    .inp_wb_addr     (wb_addr),
    .inp_wb_data     (wb_data),
    .out_valid       (o_valid),
    .inp_ex_ready    (ex_ready),
    .out_opcode      (o_opc),
    .out_rd          (o_rd),
    .out_rt          (o_rt),
    .out_rs          (o_rs),
    .out_readdata1   (o_rd1),
    .out_readdata2   (o_rd2),
    .out_SEImmidate  (o_imm)
  );

  typedef struct {
    bit          wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    bit          valid;
    logic [15:0] instr;
    bit          ex_ready;
    bit          flush;
    bit          exp_ready;
    bit          exp_valid;
    bit          chk;
    logic [2:0]  exp_opc;
    logic [2:0]  exp_rs;
    logic [2:0]  exp_rt;
    logic [2:0]  exp_rd;
    logic [15:0] exp_rd1;
    logic [15:0] exp_rd2;
    logic [15:0] exp_imm;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    wb_en    = v.wb_en;
    wb_addr  = v.wb_addr;
    wb_data  = v.wb_data;
    valid    = v.valid;
    instr    = v.instr;
    ex_ready = v.ex_ready;
    flush    = v.flush;
    #1;
    check($sformatf("v%0d ready", idx), 32'(ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    check($sformatf("v%0d valid", idx), 32'(o_valid), 32'(v.exp_valid));
    if (v.chk) begin
      check($sformatf("v%0d opcode", idx), 32'(o_opc), 32'(v.exp_opc));
      check($sformatf("v%0d rs", idx), 32'(o_rs), 32'(v.exp_rs));
      check($sformatf("v%0d rt", idx), 32'(o_rt), 32'(v.exp_rt));
      check($sformatf("v%0d rd", idx), 32'(o_rd), 32'(v.exp_rd));
      check($sformatf("v%0d rdata1", idx), 32'(o_rd1), 32'(v.exp_rd1));
      check($sformatf("v%0d rdata2", idx), 32'(o_rd2), 32'(v.exp_rd2));
      check($sformatf("v%0d imm", idx), 32'(o_imm), 32'(v.exp_imm));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid"}, 32'(o_valid), 32'h0);
    check({tag, " opcode"}, 32'(o_opc), 32'h0);
    check({tag, " rs"}, 32'(o_rs), 32'h0);
    check({tag, " rt"}, 32'(o_rt), 32'h0);
    check({tag, " rd"}, 32'(o_rd), 32'h0);
    check({tag, " rdata1"}, 32'(o_rd1), 32'h0);
    check({tag, " rdata2"}, 32'(o_rd2), 32'h0);
    check({tag, " imm"}, 32'(o_imm), 32'h0);
  endtask

  initial begin
    // wb_en wb_addr wb_data | valid instr | ex_rdy flush | exp: ready valid chk opc rs rt rd rd1 rd2 imm
    vecs[0]  = '{1, 3'd1, 16'h1234, 0, 16'h0000, 1, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0};
    vecs[1]  = '{1, 3'd2, 16'h00FF, 0, 16'h0000, 1, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0};
    vecs[2]  = '{0, 3'd0, 16'h0000, 1, 16'h8510, 1, 0, 1, 1, 1, 3'd4, 3'd1, 3'd2, 3'd1, 16'h1234, 16'h00FF, 16'h0000};
    vecs[3]  = '{1, 3'd5, 16'hBEEF, 1, 16'hD76A, 1, 0, 1, 1, 1, 3'd6, 3'd5, 3'd6, 3'd6, 16'hBEEF, 16'h0000, 16'hFFFA};
    vecs[4]  = '{0, 3'd0, 16'h0000, 1, 16'h85B1, 1, 0, 1, 1, 1, 3'd4, 3'd1, 3'd3, 3'd3, 16'h1234, 16'h0000, 16'h0001};
    vecs[5]  = '{1, 3'd3, 16'h0033, 1, 16'h0D4F, 1, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0};
    vecs[6]  = '{0, 3'd0, 16'h0000, 1, 16'h0D4F, 1, 0, 1, 1, 1, 3'd0, 3'd3, 3'd2, 3'd4, 16'h0033, 16'h00FF, 16'hFFFF};
    vecs[7]  = '{0, 3'd0, 16'h0000, 1, 16'h28A7, 1, 0, 1, 1, 1, 3'd1, 3'd2, 3'd1, 3'd2, 16'h00FF, 16'h1234, 16'h0007};
    vecs[8]  = '{0, 3'd0, 16'h0000, 1, 16'h44F8, 0, 0, 0, 1, 1, 3'd1, 3'd2, 3'd1, 3'd2, 16'h00FF, 16'h1234, 16'h0007};
    vecs[9]  = vecs[8];
    vecs[10] = vecs[8];
    vecs[11] = '{0, 3'd0, 16'h0000, 1, 16'h44F8, 1, 0, 1, 1, 1, 3'd2, 3'd1, 3'd1, 3'd7, 16'h1234, 16'h1234, 16'hFFF8};
    vecs[12] = '{1, 3'd0, 16'hFFFF, 0, 16'h0000, 1, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0};
    vecs[13] = '{1, 3'd0, 16'hAAAA, 1, 16'h6005, 1, 0, 1, 1, 1, 3'd3, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0005};
    vecs[14] = '{1, 3'd4, 16'h4444, 1, 16'h28A7, 0, 1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0};
    vecs[15] = '{0, 3'd0, 16'h0000, 1, 16'h1010, 1, 0, 1, 1, 1, 3'd0, 3'd4, 3'd0, 3'd1, 16'h4444, 16'h0000, 16'h0000};

    rst      = 1'b1;
    instr    = '0;
    valid    = 1'b0;
    flush    = 1'b0;
    wb_en    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    ex_ready = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset ready", 32'(ready), 32'h1);

    for (int i = 0; i < NVEC; i++) apply(vecs[i], i);

    // Stall with a live ID/EX entry, then reset asynchronously mid-cycle.
    @(negedge clk);
    wb_en    = 1'b0;
    flush    = 1'b0;
    valid    = 1'b1;
    instr    = 16'h44F8;
    ex_ready = 1'b0;
    #1;
    check("stall ready", 32'(ready), 32'h0);
    @(posedge clk);
    #1;
    check("stall valid", 32'(o_valid), 32'h1);
    check("stall rdata1", 32'(o_rd1), 32'h4444);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst      = 1'b0;
    ex_ready = 1'b1;
    instr    = 16'h28A7;
    #1;
    check("post-rst ready", 32'(ready), 32'h1);
    @(posedge clk);
    #1;
    check("post-rst valid", 32'(o_valid), 32'h1);
    check("post-rst rdata1", 32'(o_rd1), 32'h0);
    check("post-rst rdata2", 32'(o_rd2), 32'h0);
    check("post-rst imm", 32'(o_imm), 32'h0007);
    @(negedge clk);
    valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised, pipelined successor to the single-cycle decode stage of the 16-bit RISC core. It slices the fetched instruction, reads two operands from an internal register file with write-through bypass from writeback, and sign-extends the immediate. It registers all results into a one-deep ID/EX pipeline register with valid/ready handshakes. It also detects load-use hazards and inserts bubbles, and supports a branch flush. It sits between fetch and execute.

## Interface
- OPC_W, 3: opcode field width
- RA_W, 3: register address width; register count is 2**RA_W
- IMM_W, 4: immediate field width
- DATA_W, 16: register/datapath width; instruction width is OPC_W+3*RA_W+IMM_W (default 16)
- LOAD_OPC, 3'b100: opcode value treated as a load (destination = rt)
- inp_clk  in  1  clock, rising edge
- inp_rst  in  1  asynchronous, active-high reset
- inp_instruction  in  OPC_W+3*RA_W+IMM_W  fields [MSB..]: opcode, rs, rt, rd, imm
- inp_valid  in  1  instruction present from fetch
- out_ready  out  1  decode accepts instruction this cycle
- inp_flush  in  1  kill the held instruction and the incoming one
- inp_wb_en / inp_wb_addr / inp_wb_data  in  1 / RA_W / DATA_W  register write port
- out_valid  out  1  ID/EX register holds a live instruction
- inp_ex_ready  in  1  execute consumes the ID/EX register
- out_opcode, out_rd, out_rt, out_rs  out  OPC_W, RA_W, RA_W, RA_W  registered fields
- out_readdata1 / out_readdata2  out  DATA_W  registered values of R[rs] / R[rt]
- out_SEImmidate  out  DATA_W  registered sign-extended imm

## Operation
- Transfer into ID/EX occurs when inp_valid && out_ready.
- out_ready = (!out_valid || inp_ex_ready) && !hazard && !inp_flush.
- hazard = out_valid && out_opcode==LOAD_OPC && inp_valid && (out_rt==rs || out_rt==rt).
  - When hazard is set and inp_ex_ready is set, out_valid goes 0 next cycle (bubble).
  - The instruction is held upstream and accepted one cycle later.
- Register file: 2**RA_W x DATA_W, all zero at reset.
  - R0 reads 0 always; writes to R0 are ignored.
  - Writes occur at inp_clk edge when inp_wb_en is set.
- Bypass: if inp_wb_en && inp_wb_addr==rs (nonzero) in the capture cycle, out_readdata1 captures inp_wb_data. The same rule applies to rt and out_readdata2.
- Sign extension: out_SEImmidate = {(DATA_W-IMM_W){imm[IMM_W-1]}, imm}.
- ID/EX update priority: flush > load (transfer) > drain (inp_ex_ready without transfer clears out_valid) > hold (all outputs stable while out_valid && !inp_ex_ready).
- inp_flush: out_valid <= 0 next edge. Incoming instruction is not accepted. Writeback still commits.
- Reset (any time, mid-stall included): out_valid=0, all data/field outputs 0, register file cleared, out_ready evaluates to 1 after release.

## Timing
- Latency is 1 cycle: instruction accepted at edge N is visible on outputs after edge N.
- Throughput is 1 instruction per cycle without hazards.
- A load-use pair costs exactly 1 bubble cycle.
- out_ready is combinational from inp_valid, inp_instruction, inp_ex_ready, inp_flush and state. There is no combinational path from inputs to data outputs.
- Writeback and read of the same register in the same cycle yields the new value (bypass).
- A write at edge N is visible to reads from cycle N onward.

## Structure
- Package decode_pkg holds field offset/width localparams derived from OPC_W/RA_W/IMM_W, the LOAD_OPC default, and a function for sign extension.
- Sub-module decode_regfile holds the 2-read/1-write array with R0 hardwiring and write-through bypass.
- The top holds the ID/EX register, handshake and hazard logic.

## Test plan
- Reset, write R1=0x1234 and R2=0x00FF, then issue 16'b100_001_010_001_0000 -> next cycle: out_opcode=4, out_readdata1=0x1234, out_readdata2=0x00FF, out_rd=1, out_SEImmidate=0x0000.
- Issue 16'b110_101_110_110_1010 -> out_SEImmidate=0xFFFA, out_rt=6, out_rd=6. The same-cycle wb R5=0xBEEF gives out_readdata1=0xBEEF.
- Load (opcode 100, rt=3), then an instruction with rs=3 back-to-back -> out_ready=0 for 1 cycle, one bubble (out_valid=0), the dependent instruction emerges the following cycle.
- Hold inp_ex_ready=0 for 3 cycles with out_valid=1 -> outputs stable, out_ready=0. Release -> next instruction enters in the same cycle.
- Write R0=0xFFFF, then read rs=0 -> out_readdata1=0x0000.
- Assert inp_flush with valid ID/EX and incoming instruction -> out_valid=0 next cycle and the instruction is not accepted. Then assert inp_rst mid-stall -> all outputs 0 immediately, registers read 0 afterwards.
